// File: rtl/cache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_pkg
// Purpose : shared cache geometry and controller state encoding used by the
//           direct-mapped cache controller and its helper modules.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package cache_ctrl_pkg;

   // Geometry: one 32-bit word per line, so the line offset is just the
   // byte offset inside that word.
   localparam int INDEX_LENGTH   = 4;
   localparam int CACHE_LINE_NUM = 1 << INDEX_LENGTH;
   localparam int TAG_LENGTH     = 32 - INDEX_LENGTH - 2;

   // Controller states, two-bit encoding.
   typedef enum logic [1:0] {
      CC_IDLE   = 2'd0,
      CC_MISS   = 2'd1,
      CC_REFILL = 2'd2,
      CC_WRITE  = 2'd3
   } cc_state_e;

endpackage : cache_ctrl_pkg

// File: rtl/cache_valid_bits.sv
// ---------------------------------------------------------------------------
// cache_valid_bits
// Purpose : per-line valid bit array with an asynchronous active-low clear
//           and a single set port. Kept separate so a set-associative
//           controller can instantiate one array per way.
// Ports   : clk       - clock
//           rst       - asynchronous active-low reset, clears every bit
//           set_en    - set the bit addressed by set_index on the next edge
//           set_index - line to mark valid
//           valid     - current valid bits, one per line
// ---------------------------------------------------------------------------
module cache_valid_bits #(
   parameter int LINE_NUM = 16,
   parameter int INDEX_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en,
   input  logic [INDEX_W-1:0]  set_index,
   output logic [LINE_NUM-1:0] valid
);

   logic [LINE_NUM-1:0] valid_d;
   logic [LINE_NUM-1:0] valid_q;

   // Bits are only ever set here; invalidation happens solely through reset.
   always_comb begin
      valid_d = valid_q;
      if (set_en) begin
         valid_d[set_index] = 1'b1;
      end
   end

   // Valid register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign valid = valid_q;

endmodule : cache_valid_bits

// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
// Purpose : direct-mapped, write-through, no-write-allocate cache controller.
//           Looks up the CPU address against the external tag RAM, serves
//           read hits in the request cycle, refills on read misses and
//           forwards every write to memory (updating the data RAM on hits).
// Ports   : clk, rst          - clock, asynchronous active-low reset
//           cpu_req/we/addr/wdata, cpu_rdata, cpu_ready - CPU load/store port
//           tag_w_en, tag_index, tag_in, tag_out        - tag RAM port
//           data_w_en, data_in, data_out                - data RAM port
//           mem_req/we/addr/wdata, mem_rdata, mem_ready - memory port
// ---------------------------------------------------------------------------
module cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int OFFSET_LENGTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   output logic                    cpu_ready,
   output logic                    tag_w_en,
   output logic [INDEX_LENGTH-1:0] tag_index,
   output logic [TAG_LENGTH-1:0]   tag_in,
   input  logic [TAG_LENGTH-1:0]   tag_out,
   output logic                    data_w_en,
   output logic [DATA_WIDTH-1:0]   data_in,
   input  logic [DATA_WIDTH-1:0]   data_out,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_ready
);

   cc_state_e state_q, state_d;

   // Only the word address is kept; byte offsets never reach the memory port.
   logic [ADDR_WIDTH-1:OFFSET_LENGTH] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]             wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]             rdata_q, rdata_d;
   logic                              hit_q, hit_d;

   logic [CACHE_LINE_NUM-1:0] valid;
   logic                      valid_set;
   logic [INDEX_LENGTH-1:0]   req_index;
   logic [INDEX_LENGTH-1:0]   lat_index;
   logic [TAG_LENGTH-1:0]     req_tag;
   logic [TAG_LENGTH-1:0]     lat_tag;
   logic                      hit;
   logic                      unused_offset;

   assign req_index     = cpu_addr[OFFSET_LENGTH +: INDEX_LENGTH];
   assign req_tag       = cpu_addr[ADDR_WIDTH-1 -: TAG_LENGTH];
   assign lat_index     = addr_q[OFFSET_LENGTH +: INDEX_LENGTH];
   assign lat_tag       = addr_q[ADDR_WIDTH-1 -: TAG_LENGTH];
   assign unused_offset = ^cpu_addr[OFFSET_LENGTH-1:0];

   // The tag RAM comes out of reset holding zeros, so a tag match alone
   // would falsely hit address 0 on a cold cache; the valid bit gates it.
   // tag_out reflects req_index only while IDLE, which is the only place
   // this hit is consumed.
   assign hit = valid[req_index] && (tag_out == req_tag);

   cache_valid_bits #(
      .LINE_NUM (CACHE_LINE_NUM),
      .INDEX_W  (INDEX_LENGTH)
   ) u_valid (
      .clk       (clk),
      .rst       (rst),
      .set_en    (valid_set),
      .set_index (lat_index),
      .valid     (valid)
   );

   // Next-state and output logic. All outputs are decoded from the current
   // state (plus hit/mem_ready), so an asynchronous reset drops the strobes
   // immediately and abandons any memory transaction in flight.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      hit_d     = hit_q;
      valid_set = 1'b0;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      tag_w_en  = 1'b0;
      tag_index = lat_index;
      tag_in    = lat_tag;
      data_w_en = 1'b0;
      data_in   = rdata_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {addr_q, {OFFSET_LENGTH{1'b0}}};
      mem_wdata = wdata_q;

      unique case (state_q)
         CC_IDLE: begin
            tag_index = req_index;
            if (cpu_req) begin
               if (cpu_we) begin
                  addr_d  = cpu_addr[ADDR_WIDTH-1:OFFSET_LENGTH];
                  wdata_d = cpu_wdata;
                  hit_d   = hit;
                  state_d = CC_WRITE;
               end else if (hit) begin
                  cpu_ready = 1'b1;
                  cpu_rdata = data_out;
               end else begin
                  addr_d  = cpu_addr[ADDR_WIDTH-1:OFFSET_LENGTH];
                  state_d = CC_MISS;
               end
            end
         end

         CC_MISS: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               rdata_d = mem_rdata;
               state_d = CC_REFILL;
            end
         end

         CC_REFILL: begin
            tag_w_en  = 1'b1;
            data_w_en = 1'b1;
            valid_set = 1'b1;
            cpu_ready = 1'b1;
            cpu_rdata = rdata_q;
            state_d   = CC_IDLE;
         end

         CC_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            data_in = wdata_q;
            if (mem_ready) begin
               cpu_ready = 1'b1;
               // Write-through keeps a hit line coherent; a miss never allocates.
               data_w_en = hit_q;
               state_d   = CC_IDLE;
            end
         end

         default: state_d = CC_IDLE;
      endcase
   end

   // State and transaction registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CC_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         hit_q   <= hit_d;
      end
   end

endmodule : cache_ctrl

// File: tb/tb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl
// Purpose : self-checking bench for cache_ctrl. Provides behavioural tag and
//           data RAMs plus a memory responder, and compares every completed
//           CPU transaction against a line-level model of the cache.
// ---------------------------------------------------------------------------
module tb_cache_ctrl;
   import cache_ctrl_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    cpu_req = 1'b0;
   logic                    cpu_we = 1'b0;
   logic [31:0]             cpu_addr = '0;
   logic [31:0]             cpu_wdata = '0;
   logic [31:0]             cpu_rdata;
   logic                    cpu_ready;
   logic                    tag_w_en;
   logic [INDEX_LENGTH-1:0] tag_index;
   logic [TAG_LENGTH-1:0]   tag_in;
   logic [TAG_LENGTH-1:0]   tag_out;
   logic                    data_w_en;
   logic [31:0]             data_in;
   logic [31:0]             data_out;
   logic                    mem_req;
   logic                    mem_we;
   logic [31:0]             mem_addr;
   logic [31:0]             mem_wdata;
   logic [31:0]             mem_rdata = '0;
   logic                    mem_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   // Reference model: what each line holds, and what memory holds.
   bit                 modelValid [CACHE_LINE_NUM];
   logic [31:0]        modelTag   [CACHE_LINE_NUM];
   logic [31:0]        modelData  [CACHE_LINE_NUM];
   logic [31:0]        memModel   [logic [31:0]];

   // Free-running clock.
   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .tag_w_en  (tag_w_en),
      .tag_index (tag_index),
      .tag_in    (tag_in),
      .tag_out   (tag_out),
      .data_w_en (data_w_en),
      .data_in   (data_in),
      .data_out  (data_out),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   // Behavioural tag/data RAMs: combinational read, clocked write. The tag
   // RAM clears to zero on reset, which is what makes address 0 dangerous.
   logic [TAG_LENGTH-1:0] tagRam  [CACHE_LINE_NUM];
   logic [31:0]           dataRam [CACHE_LINE_NUM];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CACHE_LINE_NUM; i++) tagRam[i] <= '0;
      end else begin
         if (tag_w_en)  tagRam[tag_index]  <= tag_in;
         if (data_w_en) dataRam[tag_index] <= data_in;
      end
   end

   assign tag_out  = tagRam[tag_index];
   assign data_out = dataRam[tag_index];

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Memory contents; untouched words get a random value on first read.
   function automatic logic [31:0] memRead(input logic [31:0] wordAddr);
      if (!memModel.exists(wordAddr)) memModel[wordAddr] = $urandom;
      return memModel[wordAddr];
   endfunction

   // One complete CPU transaction. memDelay is the number of mem_req cycles
   // that pass before mem_ready is given (0 = ready in the first one).
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int memDelay);
      int          idx;
      logic [31:0] lineTag;
      logic [31:0] wordAddr;
      logic [31:0] expData;
      bit          expHit;
      int          expCycles;
      int          memCount;
      int          cycle;
      bit          done;

      idx       = int'((addr >> 2) % CACHE_LINE_NUM);
      lineTag   = addr >> (2 + INDEX_LENGTH);
      wordAddr  = addr & ~32'h3;
      expHit    = modelValid[idx] && (modelTag[idx] == lineTag);
      expData   = 32'h0;
      if (!we) expData = expHit ? modelData[idx] : memRead(wordAddr);
      if (we)          expCycles = memDelay + 2;
      else if (expHit) expCycles = 1;
      else             expCycles = memDelay + 3;
      memCount = 0;
      cycle    = 0;
      done     = 1'b0;

      @(posedge clk); #1;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;

      while (!done && cycle < 40) begin
         cycle++;
         if (cycle > 1) begin
            @(posedge clk); #1;
         end
         mem_ready = 1'b0;
         mem_rdata = $urandom;
         if (mem_req) begin
            if (memCount == memDelay) begin
               mem_ready = 1'b1;
               if (!we) mem_rdata = expData;
            end
            memCount++;
         end
         @(negedge clk);
         if (cycle == 1) checkOutput("idleMemReq", 32'(mem_req), 32'd0);
         if (mem_req) begin
            checkOutput("memAddr", mem_addr, wordAddr);
            checkOutput("memWe", 32'(mem_we), 32'(we));
            if (we) checkOutput("memWdata", mem_wdata, wdata);
         end
         if (cpu_ready) begin
            done = 1'b1;
            checkOutput("latency", 32'(cycle), 32'(expCycles));
            if (!we) checkOutput("rdata", cpu_rdata, expData);
            checkOutput("dataWen", 32'(data_w_en), we ? 32'(expHit) : 32'(!expHit));
            checkOutput("tagWen", 32'(tag_w_en), 32'(!we && !expHit));
            if (!we && !expHit) checkOutput("tagIn", 32'(tag_in), lineTag);
            if (we && expHit)   checkOutput("dataIn", data_in, wdata);
         end
      end
      if (!done) checkOutput("timeout", 32'(cycle), 32'(expCycles));

      if (we) begin
         memModel[wordAddr] = wdata;
         if (expHit) modelData[idx] = wdata;
      end else if (!expHit) begin
         modelValid[idx] = 1'b1;
         modelTag[idx]   = lineTag;
         modelData[idx]  = expData;
      end
   endtask

   task automatic idleCycle();
      @(posedge clk); #1;
      cpu_req   = 1'b0;
      mem_ready = 1'b0;
   endtask

   // Safety net in case the DUT wedges the bench.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      for (int i = 0; i < CACHE_LINE_NUM; i++) modelValid[i] = 1'b0;
      memModel[32'h0000_0000] = 32'hDEAD_BEEF;

      repeat (2) @(negedge clk);
      checkOutput("rstCpuReady", 32'(cpu_ready), 32'd0);
      checkOutput("rstMemReq", 32'(mem_req), 32'd0);
      checkOutput("rstTagWen", 32'(tag_w_en), 32'd0);
      checkOutput("rstDataWen", 32'(data_w_en), 32'd0);
      checkOutput("rstMemAddr", mem_addr, 32'd0);
      #2 rst = 1'b1;

      // Cold read of address 0 must miss despite tag RAM holding zero.
      applyStimulus(1'b0, 32'h0000_0000, 32'h0, 2);
      applyStimulus(1'b0, 32'h0000_0000, 32'h0, 0);
      // Same index, different tag: replaces the line, old address misses.
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1);
      applyStimulus(1'b0, 32'h0000_0000, 32'h0, 1);
      // Write hit then read back.
      applyStimulus(1'b1, 32'h0000_0000, 32'h1234_5678, 1);
      applyStimulus(1'b0, 32'h0000_0000, 32'h0, 0);
      // Write miss to the last, still cold, index; it must not allocate.
      applyStimulus(1'b1, 32'h0000_003C, 32'hCAFE_F00D, 2);
      applyStimulus(1'b0, 32'h0000_003C, 32'h0, 0);
      applyStimulus(1'b0, 32'h0000_003D, 32'h0, 0);
      // Memory ready in the very first MISS cycle.
      applyStimulus(1'b0, 32'h0000_0080, 32'h0, 0);
      applyStimulus(1'b0, 32'h0000_0000, 32'h0, 0);
      idleCycle();

      // Reset in the middle of a miss abandons it.
      @(posedge clk); #1;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h0000_0044;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("midMissMemReq", 32'(mem_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("asyncRstMemReq", 32'(mem_req), 32'd0);
      checkOutput("asyncRstCpuReady", 32'(cpu_ready), 32'd0);
      cpu_req = 1'b0;
      for (int i = 0; i < CACHE_LINE_NUM; i++) modelValid[i] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0000_003C, 32'h0, 1);
      applyStimulus(1'b0, 32'h0000_0000, 32'h0, 0);

      // Randomized traffic over a small tag pool so hits and conflicts recur.
      for (int n = 0; n < 250; n++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 3)) << (2 + INDEX_LENGTH))
           | (32'($urandom_range(0, CACHE_LINE_NUM - 1)) << 2)
           | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | 32'hFC00_0000;
         applyStimulus($urandom_range(0, 2) == 0, a, $urandom, int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) idleCycle();
      end

      idleCycle();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule : tb_cache_ctrl
